// File: rtl/riscv_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit layout and the serialiser state type.
package riscv_mmio_pkg;

  localparam logic [2:0] TXDATA_OFS = 3'h0;
  localparam logic [2:0] STATUS_OFS = 3'h4;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_ACTIVE  = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                              input logic active, input logic ovf,
                                              input logic [STAT_CNT_W-1:0] cnt);
    logic [31:0] w;
    w = '0;
    w[STAT_FULL]   = full;
    w[STAT_EMPTY]  = empty;
    w[STAT_ACTIVE] = active;
    w[STAT_OVF]    = ovf;
    w[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers; the head entry is visible on
// dout combinationally so a pop can consume it in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // push/pop are one-cycle strobes: pop is honoured only when non-empty, push
  // only when not full unless a pop frees the head slot in the same cycle.
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, STATUS register, byte FIFO
// and a baud-timed serialiser FSM driving a registered tx line.
module mmio_uart_tx
  import riscv_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        Sel,
  output logic        tx,
  output logic        busy,
  output uart_state_t fsm_state
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT-1);

  uart_state_t   state, state_nx;
  logic [BW-1:0] baud, baud_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    shift, shift_nx;
  logic          tx_nx;
  logic          overflow;
  logic          pop;
  logic          bit_end;

  logic          push_req;
  logic          status_wr;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   count_ext;
  logic          unused_bits;

  assign Sel       = (DataAdr[31:3] == BASE_ADDR[31:3]);
  assign push_req  = MemWrite & Sel & (DataAdr[2] == TXDATA_OFS[2]);
  assign status_wr = MemWrite & Sel & (DataAdr[2] == STATUS_OFS[2]);
  assign count_ext = 32'(fifo_count);
  assign unused_bits = ^{DataAdr[1:0], WriteData[31:8], count_ext[31:STAT_CNT_W]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    ReadData = '0;
    if (Sel && (DataAdr[2] == STATUS_OFS[2])) begin
      ReadData = pack_status(fifo_full, fifo_empty, state != ST_IDLE, overflow,
                             count_ext[STAT_CNT_W-1:0]);
    end
  end

  // A store that finds the FIFO full is dropped unless a pop frees a slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (status_wr) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nx;
      baud    <= baud_nx;
      bit_idx <= bit_nx;
      shift   <= shift_nx;
      tx      <= tx_nx;
    end
  end

  assign bit_end = (baud == BAUD_LAST);

  always_comb begin
    state_nx = state;
    baud_nx  = baud + BW'(1);
    bit_nx   = bit_idx;
    shift_nx = shift;
    tx_nx    = tx;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_nx = '0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_nx = fifo_dout;
          tx_nx    = 1'b0;
          state_nx = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          baud_nx  = '0;
          bit_nx   = '0;
          tx_nx    = shift[0];
          state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_nx = '0;
          if (bit_idx == 3'd7) begin
            tx_nx    = 1'b1;
            state_nx = ST_STOP;
          end else begin
            bit_nx   = bit_idx + 3'd1;
            shift_nx = {1'b0, shift[7:1]};
            tx_nx    = shift[1];
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          baud_nx = '0;
          // Chain straight into the next start bit when more bytes wait.
          if (!fifo_empty) begin
            pop      = 1'b1;
            shift_nx = fifo_dout;
            tx_nx    = 1'b0;
            state_nx = ST_START;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: begin
        baud_nx  = '0;
        tx_nx    = 1'b1;
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign busy      = (state != ST_IDLE) | ~fifo_empty;
  assign fsm_state = state;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: scenario tasks drive the bus, a tx
// frame monitor pops expected bytes from a queue and checks each frame bit-by-bit.
module tb_mmio_uart_tx;
  import riscv_mmio_pkg::*;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] ReadData;
  logic        Sel;
  logic        tx;
  logic        busy;
  uart_state_t fsm_state;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .DataAdr(DataAdr), .WriteData(WriteData),
    .MemWrite(MemWrite), .ReadData(ReadData), .Sel(Sel), .tx(tx), .busy(busy),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] d);
    DataAdr   = adr;
    WriteData = d;
    MemWrite  = 1'b1;
    step();
    bus_idle();
  endtask

  task automatic read_status(output logic [31:0] v);
    MemWrite = 1'b0;
    DataAdr  = BASE + 32'd4;
    #1;
    v = ReadData;
    DataAdr = '0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 3000) begin
      step();
      n++;
    end
    compared++;
    if (n >= 3000) begin
      mismatched++;
      $display("FAIL %s_drain: busy=%b pending=%0d after %0d cycles, required idle and none pending",
               name, busy, exp_q.size(), n);
    end
  endtask

  // scoreboard: frame monitor sampling tx every falling edge
  initial begin
    logic [9:0] bits;
    logic       bad;
    logic       aborted;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        bits = '0;
        bad = 1'b0;
        aborted = 1'b0;
        for (int i = 0; i < 10 && !aborted; i++) begin
          for (int j = 0; j < CPB && !aborted; j++) begin
            if (i != 0 || j != 0) begin
              @(negedge clk);
              if (reset !== 1'b0) aborted = 1'b1;
            end
            if (!aborted) begin
              if (j == 0) bits[i] = tx;
              else if (tx !== bits[i]) bad = 1'b1;
            end
          end
        end
        if (!aborted) begin
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL frame_unexpected: got frame %b, required no frame", bits);
          end else begin
            exp = exp_q.pop_front();
            if (bad || bits[0] !== 1'b0 || bits[9] !== 1'b1 || bits[8:1] !== exp) begin
              mismatched++;
              $display("FAIL frame_data: got frame %b (unstable=%b), required data %02h with start 0 stop 1",
                       bits, bad, exp);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    logic [31:0] s;
    reset = 1'b1;
    bus_idle();
    repeat (3) step();
    reset = 1'b0;
    repeat (20) step();
    compared++;
    if (tx !== 1'b1) begin mismatched++; $display("FAIL reset_tx: got %b, required 1", tx); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b, required 0", busy); end
    read_status(s);
    compared++;
    if (s !== 32'h0000_0002) begin mismatched++; $display("FAIL reset_status: got %08h, required 00000002", s); end
    compared++;
    if (fsm_state !== ST_IDLE) begin mismatched++; $display("FAIL reset_state: got %0d, required IDLE", fsm_state); end
  endtask

  task automatic test_single();
    int n;
    exp_q.push_back(8'hA5);
    store(BASE, 32'hFFFF_FFA5);
    compared++;
    if (tx !== 1'b1) begin mismatched++; $display("FAIL single_tx_edge1: got %b, required 1", tx); end
    step();
    compared++;
    if (tx !== 1'b0) begin mismatched++; $display("FAIL single_start_latency: got %b, required 0", tx); end
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      step();
      n++;
    end
    compared++;
    if (n != 10 * CPB) begin mismatched++; $display("FAIL single_busy_len: got %0d cycles, required %0d", n, 10 * CPB); end
    wait_drain("single");
  endtask

  task automatic test_back_to_back();
    logic [31:0] s;
    int c_store;
    c_store = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) exp_q.push_back(8'(i));
      store(BASE, 32'(i));
      if (i == 1) c_store = cyc;
    end
    read_status(s);
    compared++;
    if (s !== 32'h0000_040D) begin mismatched++; $display("FAIL b2b_status_full: got %08h, required 0000040d", s); end
    while (busy === 1'b1 && (cyc - c_store) < 1000) step();
    // first frame starts one edge after the first store; busy falls after the 5th stop bit
    compared++;
    if (cyc - c_store != 1 + 5 * 10 * CPB) begin
      mismatched++;
      $display("FAIL b2b_burst_len: got %0d cycles, required %0d", cyc - c_store, 1 + 5 * 10 * CPB);
    end
    wait_drain("b2b");
    read_status(s);
    compared++;
    if (s !== 32'h0000_000A) begin mismatched++; $display("FAIL b2b_ovf_sticky: got %08h, required 0000000a", s); end
    store(BASE + 32'd4, 32'hDEAD_BEEF);
    read_status(s);
    compared++;
    if (s !== 32'h0000_0002) begin mismatched++; $display("FAIL b2b_ovf_clear: got %08h, required 00000002", s); end
  endtask

  task automatic test_full_pop();
    logic [31:0] s;
    int n;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i * 8'h11));
      store(BASE, 32'(i * 8'h11));
    end
    read_status(s);
    compared++;
    if (s !== 32'h0000_0405) begin mismatched++; $display("FAIL fullpop_prefill: got %08h, required 00000405", s); end
    n = 0;
    while (fsm_state !== ST_STOP && n < 200) begin
      step();
      n++;
    end
    compared++;
    if (n >= 200) begin mismatched++; $display("FAIL fullpop_reach_stop: got state %0d, required STOP", fsm_state); end
    repeat (CPB - 1) step();
    exp_q.push_back(8'h66);
    store(BASE, 32'h0000_0066);
    read_status(s);
    compared++;
    if (s !== 32'h0000_0405) begin mismatched++; $display("FAIL fullpop_status: got %08h, required 00000405", s); end
    compared++;
    if (fsm_state !== ST_START) begin mismatched++; $display("FAIL fullpop_state: got %0d, required START", fsm_state); end
    wait_drain("fullpop");
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      store(BASE, {24'h0, b});
      repeat ($urandom_range(0, 3)) step();
    end
    wait_drain("random");
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    int n;
    int bad;
    store(BASE, 32'h77);
    store(BASE, 32'h88);
    store(BASE, 32'h99);
    n = 0;
    while (fsm_state !== ST_DATA && n < 100) begin
      step();
      n++;
    end
    compared++;
    if (n >= 100) begin mismatched++; $display("FAIL resetmid_reach_data: got state %0d, required DATA", fsm_state); end
    repeat (5) step();
    reset = 1'b1;
    exp_q.delete();
    step();
    compared++;
    if (tx !== 1'b1) begin mismatched++; $display("FAIL resetmid_tx: got %b, required 1", tx); end
    read_status(s);
    compared++;
    if (s !== 32'h0000_0002) begin mismatched++; $display("FAIL resetmid_status: got %08h, required 00000002", s); end
    reset = 1'b0;
    bad = 0;
    repeat (60) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL resetmid_quiet: got %0d active cycles, required 0", bad); end
  endtask

  task automatic test_decode();
    logic [31:0] s;
    DataAdr = BASE + 32'd8;
    #1;
    compared++;
    if (Sel !== 1'b0) begin mismatched++; $display("FAIL decode_sel_base8: got %b, required 0", Sel); end
    DataAdr = BASE - 32'd4;
    #1;
    compared++;
    if (Sel !== 1'b0) begin mismatched++; $display("FAIL decode_sel_below: got %b, required 0", Sel); end
    DataAdr = BASE;
    #1;
    compared++;
    if (Sel !== 1'b1 || ReadData !== 32'h0) begin
      mismatched++;
      $display("FAIL decode_txdata_read: got sel=%b data=%08h, required sel=1 data=00000000", Sel, ReadData);
    end
    DataAdr = BASE + 32'd7;
    #1;
    compared++;
    if (Sel !== 1'b1 || ReadData !== 32'h0000_0002) begin
      mismatched++;
      $display("FAIL decode_status_lowbits: got sel=%b data=%08h, required sel=1 data=00000002", Sel, ReadData);
    end
    bus_idle();
    store(BASE + 32'd8, 32'h5A);
    store(32'h0000_0010, 32'hC3);
    store(BASE + 32'd12, 32'h3C);
    read_status(s);
    compared++;
    if (s !== 32'h0000_0002) begin mismatched++; $display("FAIL decode_no_push: got %08h, required 00000002", s); end
    repeat (5) step();
    compared++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      mismatched++;
      $display("FAIL decode_no_frame: got busy=%b tx=%b, required busy=0 tx=1", busy, tx);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_pop();
    test_random();
    test_reset_mid();
    test_decode();
    wait_drain("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
